// File: rtl/fetch_if.sv
// ============================================================================
// Module  : fetch_if
// Brief   : Bundle of fetch-stage control, memory and IF/ID signals.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface fetch_if #(
  parameter int WORDSIZE    = 64,
  parameter int INSTSIZE    = 32,
  parameter int COUNTERSIZE = 3
);
  logic                   stall;
  logic                   branch_taken;
  logic [WORDSIZE-1:0]    branch_target;
  logic [INSTSIZE-1:0]    instruction_in;
  logic [WORDSIZE-1:0]    pc_out;
  logic [COUNTERSIZE-1:0] stage;
  logic [WORDSIZE-1:0]    ifid_pc;
  logic [INSTSIZE-1:0]    ifid_instruction;
  logic                   ifid_valid;

  // The fetch unit itself is the master: it owns the PC and the IF/ID register.
  modport master (
    input  stall, branch_taken, branch_target, instruction_in,
    output pc_out, stage, ifid_pc, ifid_instruction, ifid_valid
  );

  modport slave (
    output stall, branch_taken, branch_target, instruction_in,
    input  pc_out, stage, ifid_pc, ifid_instruction, ifid_valid
  );
endinterface

`default_nettype wire

// File: rtl/fetch.sv
// ============================================================================
// Module  : fetch
// Brief   : Instruction-fetch stage: PC, IF/ID register and fill counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch #(
  parameter int WORDSIZE    = 64,
  parameter int INSTSIZE    = 32,
  parameter int COUNTERSIZE = 3
) (
  input  logic     clk,
  input  logic     reset,
  fetch_if.master  bus
);

  localparam logic [WORDSIZE-1:0]    C_PC_STEP  = WORDSIZE'(4);
  localparam logic [WORDSIZE-1:0]    C_ALIGN    = ~WORDSIZE'(3);
  localparam logic [COUNTERSIZE-1:0] C_CNT_ONE  = COUNTERSIZE'(1);
  localparam logic [COUNTERSIZE-1:0] C_CNT_MAX  = '1;

  logic [WORDSIZE-1:0]    pc_q,         pc_d;
  logic [COUNTERSIZE-1:0] stage_q,      stage_d;
  logic [WORDSIZE-1:0]    ifid_pc_q,    ifid_pc_d;
  logic [INSTSIZE-1:0]    ifid_instr_q, ifid_instr_d;
  logic                   ifid_valid_q, ifid_valid_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= '0;
      stage_q      <= '0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      stage_q      <= stage_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  always_comb begin
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    stage_d      = (stage_q == C_CNT_MAX) ? stage_q : stage_q + C_CNT_ONE;

    // Redirect beats stall; the flushed slot becomes an all-zero bubble.
    if (bus.branch_taken) begin
      pc_d         = bus.branch_target & C_ALIGN;
      ifid_pc_d    = '0;
      ifid_instr_d = '0;
      ifid_valid_d = 1'b0;
    end else if (!bus.stall) begin
      pc_d         = pc_q + C_PC_STEP;
      ifid_pc_d    = pc_q;
      ifid_instr_d = bus.instruction_in;
      ifid_valid_d = 1'b1;
    end
  end

  assign bus.pc_out           = pc_q;
  assign bus.stage            = stage_q;
  assign bus.ifid_pc          = ifid_pc_q;
  assign bus.ifid_instruction = ifid_instr_q;
  assign bus.ifid_valid       = ifid_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch.sv
// ============================================================================
// Module  : tb_fetch
// Brief   : Directed self-checking bench for the fetch stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch;

  localparam int WORDSIZE    = 64;
  localparam int INSTSIZE    = 32;
  localparam int COUNTERSIZE = 3;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  ifid_t       sb[$];
  ifid_t       last_exp;
  logic [63:0] exp_pc;
  logic [2:0]  exp_stage;

  fetch_if #(.WORDSIZE(WORDSIZE), .INSTSIZE(INSTSIZE), .COUNTERSIZE(COUNTERSIZE)) bus ();

  fetch #(.WORDSIZE(WORDSIZE), .INSTSIZE(INSTSIZE), .COUNTERSIZE(COUNTERSIZE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] mem(input logic [63:0] a);
    logic [63:0] s;
    s = a >> 2;
    return 32'h8B00_0000 | s[31:0];
  endfunction

  assign bus.instruction_in = mem(bus.pc_out);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"},    bus.pc_out,                    64'd0);
    check({tag, "_stage"}, {61'd0, bus.stage},            64'd0);
    check({tag, "_ifpc"},  bus.ifid_pc,                   64'd0);
    check({tag, "_inst"},  {32'd0, bus.ifid_instruction}, 64'd0);
    check({tag, "_val"},   {63'd0, bus.ifid_valid},       64'd0);
  endtask

  // Drive one edge's worth of stimulus, queue the expected IF/ID, then compare.
  task automatic cycle(input string tag, input logic br, input logic [63:0] tgt, input logic st);
    ifid_t e;
    ifid_t got;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    bus.stall         = st;
    if (br) begin
      e = '{pc: 64'd0, instr: 32'd0, valid: 1'b0};
      exp_pc = {tgt[63:2], 2'b00};
    end else if (st) begin
      e = last_exp;
    end else begin
      e = '{pc: exp_pc, instr: mem(exp_pc), valid: 1'b1};
      exp_pc = exp_pc + 64'd4;
    end
    sb.push_back(e);
    if (exp_stage != 3'd7) exp_stage = exp_stage + 3'd1;
    @(posedge clk);
    #1;
    got = sb.pop_front();
    last_exp = got;
    check({tag, "_pc"},    bus.pc_out,                    exp_pc);
    check({tag, "_stage"}, {61'd0, bus.stage},            {61'd0, exp_stage});
    check({tag, "_ifpc"},  bus.ifid_pc,                   got.pc);
    check({tag, "_inst"},  {32'd0, bus.ifid_instruction}, {32'd0, got.instr});
    check({tag, "_val"},   {63'd0, bus.ifid_valid},       {63'd0, got.valid});
  endtask

  initial begin
    checks            = 0;
    failures          = 0;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    reset             = 1'b1;
    exp_pc            = 64'd0;
    exp_stage         = 3'd0;
    last_exp          = '{pc: 64'd0, instr: 32'd0, valid: 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");

    @(negedge clk);
    reset = 1'b0;

    // Fill: PC 0 -> 4 -> 8.
    cycle("adv1", 1'b0, 64'd0, 1'b0);
    cycle("adv2", 1'b0, 64'd0, 1'b0);

    // Three stalled edges at PC=8.
    for (int i = 0; i < 3; i++) cycle("stall", 1'b0, 64'd0, 1'b1);

    // Resume 8 -> 12 -> 16 -> 20.
    for (int i = 0; i < 3; i++) cycle("resume", 1'b0, 64'd0, 1'b0);

    // Unaligned redirect at PC=20.
    cycle("redir", 1'b1, 64'h103, 1'b0);
    cycle("tgt", 1'b0, 64'd0, 1'b0);

    // Keep running so the fill counter sits at its ceiling for 10+ edges.
    for (int i = 0; i < 8; i++) cycle("sat", 1'b0, 64'd0, 1'b0);

    // Redirect and stall together: redirect wins.
    cycle("brst", 1'b1, 64'h40, 1'b1);

    // Mid-cycle async reset with a pending stall and redirect.
    @(negedge clk);
    bus.stall         = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 64'h200;
    #1;
    check("pre_rst_pc",    bus.pc_out,         64'h40);
    check("pre_rst_stage", {61'd0, bus.stage}, 64'd7);
    #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("arst");
    @(posedge clk);
    #1;
    check_reset_outputs("arst_hold");
    @(negedge clk);
    reset             = 1'b0;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    sb.delete();
    exp_pc    = 64'd0;
    exp_stage = 3'd0;
    last_exp  = '{pc: 64'd0, instr: 32'd0, valid: 1'b0};

    cycle("restart", 1'b0, 64'd0, 1'b0);

    // Wrap at the top of the address space.
    cycle("hi_redir", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    cycle("wrap", 1'b0, 64'd0, 1'b0);
    cycle("post_wrap", 1'b0, 64'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch.md
# fetch

Instruction-fetch stage of the pipelined CPU: owns the program counter, the IF/ID pipeline register and the pipeline fill counter (`stage`). It sits directly upstream of decode and the hazard unit. It takes the hazard unit's `stall`, a resolved branch redirect from the MEM stage and the instruction word from instruction memory, and produces the IF/ID contents plus the fill count that the hazard unit consumes.

## Interface
Parameters:
- `WORDSIZE`, 64, PC and address width.
- `INSTSIZE`, 32, instruction width.
- `COUNTERSIZE`, 3, width of the fill counter; matches `` `COUNTERSIZE ``.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `stall`  in  1  from the hazard unit; holds PC and IF/ID.
- `branch_taken`  in  1  resolved taken branch from the MEM stage.
- `branch_target`  in  WORDSIZE  redirect address, valid when `branch_taken` is high.
- `instruction_in`  in  INSTSIZE  instruction memory read data for `pc_out`, combinational, same cycle.
- `pc_out`  out  WORDSIZE  current PC, drives the instruction memory address.
- `stage`  out  COUNTERSIZE  cycles since reset, saturating.
- `ifid_pc`  out  WORDSIZE  PC of the instruction held in IF/ID.
- `ifid_instruction`  out  INSTSIZE  instruction held in IF/ID.
- `ifid_valid`  out  1  IF/ID holds a real instruction, not a bubble.

## Operation
- Reset (asynchronous, takes effect immediately): `pc_out`=0, `stage`=0, `ifid_pc`=0, `ifid_instruction`=0, `ifid_valid`=0.
- `stage`:
  - Increments by 1 every cycle while not in reset.
  - Saturates at all-ones (3'b111) and never wraps.
  - Independent of `stall` and `branch_taken`.
- Per-edge priority: `branch_taken` > `stall` > normal advance.
- Redirect (`branch_taken`=1):
  - PC <= {`branch_target`[WORDSIZE-1:2], 2'b00}.
  - IF/ID flushed: `ifid_instruction`=0, `ifid_valid`=0, `ifid_pc`=0.
  - Overrides a simultaneous `stall`.
- Stall (`stall`=1, no redirect): PC, `ifid_pc`, `ifid_instruction` and `ifid_valid` all hold.
- Normal advance:
  - PC <= PC + 4, modulo 2^WORDSIZE; 0xFFFF_FFFF_FFFF_FFFC wraps to 0.
  - `ifid_pc` <= PC, `ifid_instruction` <= `instruction_in`, `ifid_valid` <= 1.
- PC bits [1:0] are always 0.
- Bubble encoding is all-zero instruction with valid low. Decode treats `ifid_valid`=0 as a NOP.

## Timing
- `pc_out` is registered and changes only on a clock edge or on reset.
- Latency:
  - The instruction at address A appears on `ifid_*` one edge after `pc_out`=A, provided there is no stall.
  - A redirect asserted at edge n makes `pc_out`=target after edge n. The target instruction reaches IF/ID after edge n+1.
- Stall extends both latencies by exactly the number of stalled edges; no instruction is lost or duplicated.
- `stage` reads 1 after the first edge following reset deassertion and 7 after the seventh edge, then stays at 7.
- Reset asserted mid-operation: all outputs return to reset values immediately. A pending stall or redirect is discarded.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset release, no stall, memory returns word `0x8B000000 | (addr>>2)`:
  - `pc_out` sequence is 0, 4, 8, 12.
  - `ifid_pc` lags by one edge.
  - `ifid_valid` rises after edge 1.
  - `stage` reads 1..7, then holds 7 for 10 more cycles.
- `stall` high for 3 edges at PC=8: PC stays 8 and IF/ID holds {4, instr@4, 1} for 3 edges, then resumes at 12 with no gap or duplicate.
- `branch_taken`=1, target=0x103 at PC=20: next PC=0x100, IF/ID becomes bubble (valid 0, instr 0), and instr@0x100 appears in IF/ID one edge later.
- `branch_taken` and `stall` both high on the same edge: redirect wins, PC=target and IF/ID is flushed.
- Async reset pulsed mid-cycle (between edges) while PC=0x40, `stage`=7: all outputs are 0 immediately and the counter restarts from 0.
- PC forced near the top via redirect to 0xFFFF_FFFF_FFFF_FFFC, no stall: next PC=0 and `ifid_pc`=0xFFFF_FFFF_FFFF_FFFC.
